// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner
// Walks NUM_REGS registers from a flattened bus. Each row is snapshotted
// once, converted to ASCII (signed decimal via double-dabble, or hex), and
// streamed into the text buffer with a valid/ready handshake. Each register
// gets one screen row.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   reg_bus              register i at bits [i*DATA_W +: DATA_W]
//   run                  level, high = scan continuously
//   hex_mode             0 = signed decimal, 1 = hex (sampled at frame start)
//   ascii_write_ready    text buffer accepts a write this cycle
//   ascii_write_en       write valid
//   ascii_write_address  row*COLS + column
//   ascii_input          {char, 24'hFFFFFF}
//   busy                 frame in progress
//   frame_done           one-cycle pulse after the last write of a frame
//
// Optional build macro REG_DUMP_LABEL_EN: each row is prefixed with "rNN:"
// and the value columns move right by 4.
module reg_dump_scanner #(
   parameter int NUM_REGS   = 33,
   parameter int DATA_W     = 32,
   parameter int DEC_DIGITS = 10,
   parameter int COLS       = 80,
   parameter int ROWS       = 60,
   parameter int ADDR_W     = 13,
   parameter int FRAME_GAP  = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REGS*DATA_W-1:0]   reg_bus,
   input  logic                         run,
   input  logic                         hex_mode,
   input  logic                         ascii_write_ready,
   output logic                         ascii_write_en,
   output logic [ADDR_W-1:0]            ascii_write_address,
   output logic [31:0]                  ascii_input,
   output logic                         busy,
   output logic                         frame_done
);
`ifdef REG_DUMP_LABEL_EN
   localparam int LBL = 4;
`else
   localparam int LBL = 0;
`endif
   localparam int BCD_W      = 4*DEC_DIGITS;
   localparam int HEX_DIGITS = DATA_W/4;
   localparam int ROW_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int COL_W      = $clog2(COLS+1);
   localparam int CNT_W      = $clog2(DATA_W);
   localparam int GAP_W      = $clog2(FRAME_GAP+1);
   localparam logic [COL_W-1:0] LAST_DEC = COL_W'(LBL+DEC_DIGITS);
   localparam logic [COL_W-1:0] LAST_HEX = COL_W'(LBL+HEX_DIGITS);

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_CONVERT, S_EMIT, S_NEXT_ROW, S_DONE, S_GAP
   } state_t;

   state_t             r_state;
   logic               r_hex;
   logic               r_neg;
   logic [ROW_W-1:0]   r_row;
   logic [COL_W-1:0]   r_col;
   logic [CNT_W-1:0]   r_cnt;
   logic [GAP_W-1:0]   r_gap;
   logic [DATA_W-1:0]  r_snap;
   logic [DATA_W-1:0]  r_mag;
   logic [BCD_W-1:0]   r_bcd;

   logic [DATA_W-1:0]  w_sel;
   logic [BCD_W-1:0]   w_bcd_adj;
   logic [3:0]         w_dig;
   logic [3:0]         w_nib;
   logic [COL_W-1:0]   w_last;
   logic [COL_W-1:0]   w_vcol;
   logic [7:0]         w_char;
   logic [ADDR_W-1:0]  w_addr;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
   endfunction

   assign w_sel  = reg_bus[r_row*DATA_W +: DATA_W];
   assign w_last = r_hex ? LAST_HEX : LAST_DEC;
   // column within the value field (col 0 = sign / 'x')
   assign w_vcol = r_col - COL_W'(LBL);
   assign w_addr = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);
   // digits are stored MSD at the top, so column k takes digit (N-k)
   assign w_dig  = 4'(r_bcd  >> (4*(DEC_DIGITS - int'(w_vcol))));
   assign w_nib  = 4'(r_snap >> (4*(HEX_DIGITS - int'(w_vcol))));

   // double-dabble: add 3 to every BCD digit >= 5 before each shift
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int d = 0; d < DEC_DIGITS; d++)
         if (r_bcd[d*4 +: 4] >= 4'd5) w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
   end

`ifdef REG_DUMP_LABEL_EN
   logic [3:0] w_tens, w_ones;
   assign w_tens = 4'(r_row / ROW_W'(10));
   assign w_ones = 4'(r_row % ROW_W'(10));
`endif

   always_comb begin
      if (w_vcol == '0)
         w_char = r_hex ? 8'h78 : (r_neg ? 8'h2D : 8'h2B);
      else if (r_hex)
         w_char = hex_char(w_nib);
      else
         w_char = {4'h3, w_dig};
`ifdef REG_DUMP_LABEL_EN
      if (r_col == COL_W'(0))      w_char = 8'h72;
      else if (r_col == COL_W'(1)) w_char = {4'h3, w_tens};
      else if (r_col == COL_W'(2)) w_char = {4'h3, w_ones};
      else if (r_col == COL_W'(3)) w_char = 8'h3A;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state             <= S_IDLE;
         r_hex               <= 1'b0;
         r_neg               <= 1'b0;
         r_row               <= '0;
         r_col               <= '0;
         r_cnt               <= '0;
         r_gap               <= '0;
         r_snap              <= '0;
         r_mag               <= '0;
         r_bcd               <= '0;
         ascii_write_en      <= 1'b0;
         ascii_write_address <= '0;
         ascii_input         <= '0;
         busy                <= 1'b0;
         frame_done          <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (r_state)
            S_IDLE:
               if (run) begin
                  r_state <= S_LATCH;
                  r_hex   <= hex_mode;
                  r_row   <= '0;
                  busy    <= 1'b1;
               end
            S_LATCH: begin
               r_snap  <= w_sel;
               r_neg   <= w_sel[DATA_W-1];
               // unsigned magnitude: the most-negative value maps to 2^(DATA_W-1)
               r_mag   <= w_sel[DATA_W-1] ? (~w_sel + 1'b1) : w_sel;
               r_bcd   <= '0;
               r_cnt   <= '0;
               r_col   <= '0;
               r_state <= r_hex ? S_EMIT : S_CONVERT;
            end
            S_CONVERT: begin
               r_bcd <= {w_bcd_adj[BCD_W-2:0], r_mag[DATA_W-1]};
               r_mag <= {r_mag[DATA_W-2:0], 1'b0};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(DATA_W-1)) r_state <= S_EMIT;
            end
            S_EMIT:
               // output slot is free when idle or when the current char transfers
               if (!ascii_write_en || ascii_write_ready) begin
                  if (r_col > w_last) begin
                     ascii_write_en <= 1'b0;
                     r_state        <= S_NEXT_ROW;
                  end else begin
                     ascii_write_en      <= 1'b1;
                     ascii_write_address <= w_addr;
                     ascii_input         <= {w_char, 24'hFFFFFF};
                     r_col               <= r_col + 1'b1;
                  end
               end
            S_NEXT_ROW:
               if (r_row == ROW_W'(NUM_REGS-1)) r_state <= S_DONE;
               else begin
                  r_row   <= r_row + 1'b1;
                  r_state <= S_LATCH;
               end
            S_DONE: begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
               r_gap      <= '0;
               r_state    <= S_GAP;
            end
            S_GAP:
               if (r_gap == GAP_W'(FRAME_GAP-1)) begin
                  if (run) begin
                     r_state <= S_LATCH;
                     r_hex   <= hex_mode;
                     r_row   <= '0;
                     busy    <= 1'b1;
                  end else
                     r_state <= S_IDLE;
               end else
                  r_gap <= r_gap + 1'b1;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_reg_dump_scanner.sv
// Bench for reg_dump_scanner: a frame-level text model feeds an expected-write
// queue that is checked on every transfer, plus literal screen-text checks.
module tb_reg_dump_scanner;
   localparam int NR = 33, DW = 32, COLS = 80, GAP = 1024;
`ifdef REG_DUMP_LABEL_EN
   localparam int LB = 4;
`else
   localparam int LB = 0;
`endif
   localparam int ROWLEN = LB + 11;   // chars per decimal row

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR*DW-1:0] reg_bus = '0;
   logic            run = 1'b0, hex_mode = 1'b0, ready = 1'b1;
   logic            en, busy, frame_done;
   logic [12:0]     addr;
   logic [31:0]     data;

   int errors = 0, checks = 0;
   logic [31:0] regs [NR];
   logic [44:0] expq [$];
   logic [7:0]  scr [8192];
   bit          wr  [8192];
   int          n_xfer = 0, n_done = 0;
   int          en_cyc [NR];

   always #5 clk = ~clk;

   reg_dump_scanner dut (
      .clk(clk), .rst(rst), .reg_bus(reg_bus), .run(run), .hex_mode(hex_mode),
      .ascii_write_ready(ready), .ascii_write_en(en), .ascii_write_address(addr),
      .ascii_input(data), .busy(busy), .frame_done(frame_done));

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_ch(int r, int c, logic [7:0] ch);
      expq.push_back({13'(r*COLS + c), ch, 24'hFFFFFF});
   endtask

   // Expected text for a whole frame, straight from the line-layout rules
   task automatic push_frame(bit hx);
      for (int r = 0; r < NR; r++) begin
         longint s, m;
         logic [31:0] v;
         v = regs[r];
`ifdef REG_DUMP_LABEL_EN
         push_ch(r, 0, 8'h72);
         push_ch(r, 1, 8'(8'h30 + r/10));
         push_ch(r, 2, 8'(8'h30 + r%10));
         push_ch(r, 3, 8'h3A);
`endif
         if (hx) begin
            push_ch(r, LB, 8'h78);
            for (int k = 0; k < 8; k++) begin
               int n;
               n = int'((v >> (4*(7-k))) & 32'hF);
               push_ch(r, LB+1+k, (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10));
            end
         end else begin
            s = longint'($signed(v));
            m = (s < 0) ? -s : s;
            push_ch(r, LB, (s < 0) ? 8'h2D : 8'h2B);
            for (int k = 0; k < 10; k++) begin
               longint p;
               p = 1;
               for (int j = 0; j < 9-k; j++) p = p * 10;
               push_ch(r, LB+1+k, 8'(8'h30 + (m / p) % 10));
            end
         end
      end
   endtask

   task automatic chk_str(string name, int base, string s);
      bit ok;
      string a;
      ok = 1;
      a = "";
      for (int i = 0; i < s.len(); i++) begin
         if (!wr[base+i] || scr[base+i] !== s[i]) ok = 0;
         a = $sformatf("%s%c", a, wr[base+i] ? scr[base+i] : 8'h2E);
      end
      if (wr[base + s.len()]) ok = 0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: text at %0d is \"%s\" (next written=%0d), expected \"%s\"",
                  name, base, a, wr[base + s.len()], s);
      end
   endtask

   task automatic clear_screen();
      for (int i = 0; i < 8192; i++) begin scr[i] = 8'h00; wr[i] = 0; end
      for (int i = 0; i < NR; i++) en_cyc[i] = 0;
      n_xfer = 0;
      n_done = 0;
   endtask

   task automatic wait_done(string name);
      int k;
      k = 0;
      do begin @(negedge clk); k++; end while (frame_done !== 1'b1 && k < 5000);
      checks++;
      if (k >= 5000) begin errors++; $display("FAIL %s: frame_done timeout", name); end
   endtask

   // Compare process: every accepted write against the model, plus hold checks
   logic        stall_p = 1'b0;
   logic [12:0] addr_p;
   logic [31:0] data_p;
   always @(negedge clk) begin
      if (rst) stall_p = 1'b0;
      else begin
         if (stall_p) begin
            checks++;
            if (!(en === 1'b1 && addr === addr_p && data === data_p)) begin
               errors++;
               $display("FAIL hold: en=%0b addr=%0d data=%h, expected en=1 addr=%0d data=%h",
                        en, addr, data, addr_p, data_p);
            end
         end
         if (en === 1'b1 && int'(addr)/COLS < NR) en_cyc[int'(addr)/COLS]++;
         if (en === 1'b1 && ready) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL write: unexpected write addr=%0d data=%h", addr, data);
            end else begin
               logic [44:0] e;
               e = expq.pop_front();
               if ({addr, data} !== e) begin
                  errors++;
                  $display("FAIL write: addr=%0d data=%h, expected addr=%0d data=%h",
                           addr, data, e[44:32], e[31:0]);
               end
            end
            scr[addr] = data[31:24];
            wr[addr]  = 1;
            n_xfer++;
         end
         if (frame_done === 1'b1) n_done++;
         stall_p = (en === 1'b1) && !ready;
         addr_p  = addr;
         data_p  = data;
      end
   end

   initial begin
      int k;
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      regs[0] = 32'h8000_0000; regs[1] = 32'h0000_0000; regs[3] = 32'hDEAD_BEEF;
      regs[5] = 32'hFFFF_FFD6; regs[7] = 32'h7FFF_FFFF; regs[9] = 32'h0000_0001;
      regs[11] = 32'hFFFF_FFFF;
      for (int i = 0; i < NR; i++) reg_bus[i*DW +: DW] = regs[i];
      clear_screen();

      // reset state
      #12;
      chk("rst_en", en, 0);
      chk("rst_addr", addr, 0);
      chk("rst_data", data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("idle_busy", busy, 0);
      chk("idle_en", en, 0);

      // Frame A: decimal single frame, ready stalled 5 cycles inside row 2
      push_frame(1'b0);
      @(posedge clk); #1 run = 1'b1; hex_mode = 1'b0;
      @(posedge clk); #1 run = 1'b0;
      @(negedge clk); chk("busy_a", busy, 1);
      k = 0;
      do begin @(negedge clk); k++; end while (!(en === 1'b1 && addr == 13'(2*COLS + LB + 4)) && k < 3000);
      chk("stall_reach", k < 3000, 1);
      @(posedge clk); #1 ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 ready = 1'b1;
      wait_done("frame_a");
      @(posedge clk); #1;
      chk("a_writes", n_xfer, NR*ROWLEN);
      chk("a_done_pulses", n_done, 1);
      chk("a_queue_empty", expq.size(), 0);
      chk("a_row4_en_cycles", en_cyc[4], ROWLEN);
      chk("a_row2_stall_len", en_cyc[2], en_cyc[4] + 5);
      repeat (GAP + 60) @(posedge clk);
      #1 chk("a_idle_busy", busy, 0);
      chk("a_no_restart", n_xfer, NR*ROWLEN);
      chk("a_done_once", n_done, 1);
      chk_str("dec_m42", 5*COLS + LB, "-0000000042");
      chk_str("dec_min", 0*COLS + LB, "-2147483648");
      chk_str("dec_zero", 1*COLS + LB, "+0000000000");
      chk_str("dec_max", 7*COLS + LB, "+2147483647");
      chk_str("dec_m1", 11*COLS + LB, "-0000000001");

      // Frame B: hex, run held high; hex_mode flips mid-frame and must be ignored
      clear_screen();
      push_frame(1'b1);
      @(posedge clk); #1 run = 1'b1; hex_mode = 1'b1;
      repeat (100) @(posedge clk);
      #1 hex_mode = 1'b0;
      wait_done("frame_b");
      chk("b_queue_empty", expq.size(), 0);
      chk("b_writes", n_xfer, NR*(LB+9));
      push_frame(1'b0);   // frame C, decimal
      k = 0;
      do begin @(negedge clk); k++; end while (en !== 1'b1 && k < 2000);
      checks++;
      if (k < GAP || k > GAP + 40) begin
         errors++;
         $display("FAIL gap: first write %0d cycles after frame_done, expected %0d..%0d",
                  k, GAP, GAP + 40);
      end
      chk_str("hex_dead", 3*COLS + LB, "xDEADBEEF");
      chk_str("hex_m42", 5*COLS + LB, "xFFFFFFD6");

      // Frame C: reset during row 10 emission
      k = 0;
      do begin @(negedge clk); k++; end while (!(en === 1'b1 && addr >= 13'(10*COLS)) && k < 5000);
      chk("row10_reach", k < 5000, 1);
      @(posedge clk); #3 rst = 1'b1;
      #1;
      chk("mid_rst_en", en, 0);
      chk("mid_rst_addr", addr, 0);
      chk("mid_rst_busy", busy, 0);
      expq.delete();
      clear_screen();
      push_frame(1'b0);   // frame D restarts from row 0
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (en !== 1'b1 && k < 200);
      chk("restart_addr", addr, 0);
      run = 1'b0;
      wait_done("frame_d");
      @(posedge clk); #1;
      chk("d_writes", n_xfer, NR*ROWLEN);
      chk("d_queue_empty", expq.size(), 0);
      chk_str("d_min", 0*COLS + LB, "-2147483648");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
